// File: rtl/encoder8_3_stable.sv
// 8-to-3 priority encoder with input debounce and valid/ready output.
// A non-zero line vector must be sampled unchanged for STABLE_CNT clocks
// before its priority code is emitted. Once a code is accepted, the same
// vector is not emitted again until the lines change or go idle.
module encoder8_3_stable #(
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] in,
  input  logic       out_ready,
  output logic [2:0] out,
  output logic       out_valid,
  output logic       multi_hot
);

  localparam int unsigned VEC_W  = 8;
  localparam int unsigned CODE_W = 3;
  localparam int unsigned CNT_W  = 16;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic             SINGLE   = (STABLE_CNT == 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    VALID   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [VEC_W-1:0]    in_reg;
  logic [VEC_W-1:0]    snap, snap_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [CODE_W-1:0]   out_nxt;
  logic                out_valid_nxt;
  logic                multi_hot_nxt;
  logic                start_run;
  logic                load;
  logic [VEC_W-1:0]    load_vec;

  // Index of the highest set line; bit 7 wins.
  function automatic logic [CODE_W-1:0] prio(input logic [VEC_W-1:0] v);
    logic [CODE_W-1:0] code;
    code = CODE_W'(0);
    casez (v)
      8'b1???????: code = CODE_W'(7);
      8'b01??????: code = CODE_W'(6);
      8'b001?????: code = CODE_W'(5);
      8'b0001????: code = CODE_W'(4);
      8'b00001???: code = CODE_W'(3);
      8'b000001??: code = CODE_W'(2);
      8'b0000001?: code = CODE_W'(1);
      default:     code = CODE_W'(0);
    endcase
    return code;
  endfunction

  // More than one line set: clearing the lowest set bit leaves something.
  function automatic logic several(input logic [VEC_W-1:0] v);
    return (v & (v - VEC_W'(1))) != '0;
  endfunction

  // Next-state and datapath decisions, all taken on the registered input.
  always_comb begin
    state_nxt     = state;
    snap_nxt      = snap;
    cnt_nxt       = cnt;
    out_nxt       = out;
    out_valid_nxt = out_valid;
    multi_hot_nxt = multi_hot;
    start_run     = 1'b0;
    load          = 1'b0;
    load_vec      = snap;

    case (state)
      IDLE: begin
        if (in_reg != '0) start_run = 1'b1;
      end
      COUNT: begin
        if (in_reg == '0) begin
          state_nxt = IDLE;
        end else if (in_reg != snap) begin
          start_run = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = VALID;
          load      = 1'b1;
          load_vec  = snap;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      VALID: begin
        if (out_ready) begin
          state_nxt     = RELEASE;
          out_valid_nxt = 1'b0;
        end
      end
      RELEASE: begin
        if (in_reg == '0) begin
          state_nxt = IDLE;
        end else if (in_reg != snap) begin
          start_run = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A new non-zero vector opens a run; a threshold of one emits at once.
    if (start_run) begin
      snap_nxt = in_reg;
      cnt_nxt  = CNT_ONE;
      if (SINGLE) begin
        state_nxt = VALID;
        load      = 1'b1;
        load_vec  = in_reg;
      end else begin
        state_nxt = COUNT;
      end
    end

    if (load) begin
      out_nxt       = prio(load_vec);
      multi_hot_nxt = several(load_vec);
      out_valid_nxt = 1'b1;
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      in_reg    <= '0;
      snap      <= '0;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      multi_hot <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_reg    <= in;
      snap      <= snap_nxt;
      cnt       <= cnt_nxt;
      out       <= out_nxt;
      out_valid <= out_valid_nxt;
      multi_hot <= multi_hot_nxt;
    end
  end

endmodule

// File: tb/tb_encoder8_3_stable.sv
// Bench for encoder8_3_stable: directed vector table, a hand sequence for
// the single-sample instance, and randomized traffic against a run-length
// reference model for both STABLE_CNT=4 and STABLE_CNT=1 instances.
module tb_encoder8_3_stable;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       rdy;
  logic [2:0] o4, o1;
  logic       v4, v1;
  logic       mh4, mh1;

  int compared;
  int mismatched;

  encoder8_3_stable #(.STABLE_CNT(4)) dut4 (
    .sys_clk(clk), .sys_rst(rst), .in(din), .out_ready(rdy),
    .out(o4), .out_valid(v4), .multi_hot(mh4)
  );

  encoder8_3_stable #(.STABLE_CNT(1)) dut1 (
    .sys_clk(clk), .sys_rst(rst), .in(din), .out_ready(rdy),
    .out(o1), .out_valid(v1), .multi_hot(mh1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: counts how long one non-zero value has been seen in a row,
  // holds a code while unaccepted, and suppresses the just-accepted value.
  typedef struct {
    logic [7:0] q;
    logic [7:0] cur;
    int         run;
    logic [7:0] sup;
    logic       hold;
    logic [2:0] o;
    logic       mh;
  } mstate_t;

  mstate_t m4, m1;

  function automatic mstate_t mclear();
    mstate_t r;
    r.q = 8'h00; r.cur = 8'h00; r.run = 0; r.sup = 8'h00;
    r.hold = 1'b0; r.o = 3'd0; r.mh = 1'b0;
    return r;
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input int n,
                                    input logic r, input logic [7:0] d,
                                    input logic rd);
    mstate_t x;
    int hi;
    x = s;
    if (r) return mclear();
    if (s.hold) begin
      if (rd) x.hold = 1'b0;
    end else if (s.q == 8'h00) begin
      x.run = 0;
      x.sup = 8'h00;
    end else if (s.q != s.sup) begin
      if (s.run > 0 && s.q == s.cur) x.run = s.run + 1;
      else begin
        x.cur = s.q;
        x.run = 1;
      end
      x.sup = 8'h00;
      if (x.run == n) begin
        hi = 0;
        for (int i = 0; i < 8; i++) if (x.cur[i]) hi = i;
        x.hold = 1'b1;
        x.o    = 3'(hi);
        x.mh   = ($countones(x.cur) > 1);
        x.run  = 0;
        x.sup  = x.cur;
      end
    end
    x.q = d;
    return x;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, advance models, check next falling edge.
  task automatic tick(input logic r, input logic [7:0] d, input logic rd);
    rst = r;
    din = d;
    rdy = rd;
    @(posedge clk);
    m4 = mstep(m4, 4, r, d, rd);
    m1 = mstep(m1, 1, r, d, rd);
    @(negedge clk);
    chk("m4_valid", 8'(v4),  8'(m4.hold));
    chk("m4_out",   8'(o4),  8'(m4.o));
    chk("m4_mh",    8'(mh4), 8'(m4.mh));
    chk("m1_valid", 8'(v1),  8'(m1.hold));
    chk("m1_out",   8'(o1),  8'(m1.o));
    chk("m1_mh",    8'(mh1), 8'(m1.mh));
  endtask

  typedef struct {
    logic       r;
    logic [7:0] d;
    logic       rd;
    int         n;
    logic       ev;
    logic [2:0] eo;
    logic       em;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [7:0] d, input logic rd, input int n,
                     input logic ev, input logic [2:0] eo, input logic em);
    vec_t v;
    v.r = r; v.d = d; v.rd = rd; v.n = n; v.ev = ev; v.eo = eo; v.em = em;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] val;
    int         len;
    compared   = 0;
    mismatched = 0;
    m4 = mclear();
    m1 = mclear();
    rst = 1'b1;
    din = 8'h00;
    rdy = 1'b1;

    // Segments of {reset, in, ready, cycles} with STABLE_CNT=4 outputs at segment end.
    add(1, 8'h00, 1,  1, 0, 3'd0, 0);
    add(0, 8'h04, 1,  4, 0, 3'd0, 0);
    add(0, 8'h04, 1,  1, 1, 3'd2, 0);
    add(0, 8'h04, 1,  1, 0, 3'd2, 0);
    add(0, 8'h04, 1, 14, 0, 3'd2, 0);
    add(0, 8'h00, 1,  2, 0, 3'd2, 0);
    add(0, 8'h80, 1,  4, 0, 3'd2, 0);
    add(0, 8'h80, 1,  1, 1, 3'd7, 0);
    add(0, 8'h80, 1,  1, 0, 3'd7, 0);
    add(1, 8'h00, 1,  1, 0, 3'd0, 0);
    add(0, 8'h08, 1,  2, 0, 3'd0, 0);
    add(0, 8'h00, 1,  6, 0, 3'd0, 0);
    add(0, 8'h08, 1,  2, 0, 3'd0, 0);
    add(0, 8'h10, 1,  4, 0, 3'd0, 0);
    add(0, 8'h10, 1,  1, 1, 3'd4, 0);
    add(0, 8'h10, 1,  3, 0, 3'd4, 0);
    add(1, 8'h00, 1,  1, 0, 3'd0, 0);
    add(0, 8'h26, 1,  4, 0, 3'd0, 0);
    add(0, 8'h26, 1,  1, 1, 3'd5, 1);
    add(0, 8'h26, 1,  1, 0, 3'd5, 1);
    add(1, 8'h00, 0,  1, 0, 3'd0, 0);
    add(0, 8'h01, 0,  4, 0, 3'd0, 0);
    add(0, 8'h01, 0,  1, 1, 3'd0, 0);
    add(0, 8'h01, 0,  3, 1, 3'd0, 0);
    add(0, 8'h40, 0,  5, 1, 3'd0, 0);
    add(0, 8'h40, 1,  1, 0, 3'd0, 0);
    add(0, 8'h40, 1,  3, 0, 3'd0, 0);
    add(0, 8'h40, 1,  1, 1, 3'd6, 0);
    add(1, 8'h00, 0,  1, 0, 3'd0, 0);
    add(0, 8'h10, 0,  5, 1, 3'd4, 0);
    add(1, 8'h10, 0,  1, 0, 3'd0, 0);
    add(0, 8'h10, 1,  4, 0, 3'd0, 0);
    add(0, 8'h10, 1,  1, 1, 3'd4, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].n; k++) tick(vecs[i].r, vecs[i].d, vecs[i].rd);
      chk($sformatf("row%0d_valid", i), 8'(v4),  8'(vecs[i].ev));
      chk($sformatf("row%0d_out", i),   8'(o4),  8'(vecs[i].eo));
      chk($sformatf("row%0d_mh", i),    8'(mh4), 8'(vecs[i].em));
    end

    // Single-sample instance: code appears one edge after the first sample.
    tick(1, 8'h00, 1);
    tick(0, 8'h02, 1);
    chk("n1_edge0_valid", 8'(v1), 8'h00);
    tick(0, 8'h02, 1);
    chk("n1_edge1_valid", 8'(v1), 8'h01);
    chk("n1_edge1_out",   8'(o1), 8'h01);
    chk("n1_edge1_mh",    8'(mh1), 8'h00);
    tick(0, 8'h02, 1);
    chk("n1_edge2_valid", 8'(v1), 8'h00);

    // Randomized held values with random backpressure and rare resets.
    for (int seg = 0; seg < 300; seg++) begin
      case ($urandom_range(0, 5))
        0: val = 8'h00;
        1: val = 8'h01;
        2: val = 8'h04;
        3: val = 8'h26;
        4: val = 8'h80;
        default: val = 8'($urandom);
      endcase
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++)
        tick(($urandom_range(0, 199) == 0), val, ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
